// File: rtl/sram_mem_responder_pkg.sv
// sram_mem_responder_pkg: request op codes, default SRAM width and FSM states
package sram_mem_responder_pkg;
  localparam int DEF_SRAM_AW = 20;
  localparam logic [1:0] ROM_OP_NOP   = 2'b00;
  localparam logic [1:0] ROM_OP_INST  = 2'b01;
  localparam logic [1:0] ROM_OP_LOAD  = 2'b10;
  localparam logic [1:0] ROM_OP_STORE = 2'b11;
  typedef enum logic [2:0] {IDLE, READ, WSETUP, WPULSE, WHOLD, DONE} state_t;
endpackage

// File: rtl/sram_bus_tristate.sv
// sram_bus_tristate: bidirectional SRAM data buffer, drives the bus only when enabled
module sram_bus_tristate (
  input  logic        drive_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  inout  wire  [31:0] bus_io
);
  assign bus_io = drive_i ? data_i : 'z;
  assign data_o = bus_io;
endmodule

// File: rtl/sram_mem_responder.sv
// sram_mem_responder: multi-cycle async SRAM access FSM serving fetch/load/store with pipeline stall
module sram_mem_responder
  import sram_mem_responder_pkg::*;
#(
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2,
  parameter int SRAM_AW      = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce_i,
  input  logic [1:0]         rom_op_i,
  input  logic [31:0]        rw_addr_i,
  input  logic [31:0]        wr_data_i,
  input  logic [3:0]         be_i,
  input  logic               flush_i,
  output logic [31:0]        rd_data_o,
  output logic               stall_req_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  inout  wire  [31:0]        sram_data_io,
  output logic [3:0]         sram_be_n_o,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o
);
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [3:0] be_q, be_d;
  logic [31:0] wdata_q, wdata_d, rd_q, rd_d, bus_in;
  logic valid, wr_st, unused_addr;
  assign valid = ce_i && rom_op_i != ROM_OP_NOP && !flush_i;
  assign wr_st = state_q inside {WSETUP, WPULSE, WHOLD};
  assign unused_addr = ^{rw_addr_i[31:SRAM_AW+2], rw_addr_i[1:0]};
  sram_bus_tristate u_bus (
    .drive_i(wr_st),
    .data_i (wdata_q),
    .data_o (bus_in),
    .bus_io (sram_data_io)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: if (valid) begin
        addr_d  = rw_addr_i[SRAM_AW+1:2];
        be_d    = be_i;
        wdata_d = wr_data_i;
        cnt_d   = '0;
        state_d = rom_op_i == ROM_OP_STORE ? WSETUP : READ;
      end
      READ: if (flush_i) state_d = IDLE;
        else if (cnt_q == 3'(READ_CYCLES - 1)) begin
          rd_d    = bus_in;
          state_d = DONE;
        end else cnt_d = cnt_q + 3'd1;
      WSETUP: begin
        cnt_d   = '0;
        state_d = WPULSE;
      end
      WPULSE: if (cnt_q == 3'(WRITE_CYCLES - 1)) state_d = WHOLD;
        else cnt_d = cnt_q + 3'd1;
      WHOLD:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
    end
  end
  // Strobes decode straight from state so an async reset releases them at once
  assign stall_req_o = (state_q == IDLE && valid) || (state_q == READ && !flush_i) || wr_st;
  assign sram_ce_n_o = !(state_q == READ || wr_st);
  assign sram_oe_n_o = state_q != READ;
  assign sram_we_n_o = state_q != WPULSE;
  assign sram_be_n_o = state_q == READ ? 4'b0000 : wr_st ? ~be_q : 4'b1111;
  assign sram_addr_o = addr_q;
  assign rd_data_o   = rd_q;
endmodule
